dcache_ctrl: RTL

Direct-mapped, write-through, no-write-allocate data cache controller sitting directly downstream of the memory-access stage. It consumes that stage's `Dcache_bus_out` request bus and returns `Dcache_bus_in` (hit + read data), from which the stage derives `miss` and stalls the pipeline. On misses and on all writes it runs a strobe/ack transaction with the backing RAM. It holds the pipeline via a deasserted hit until the transaction completes.

---
 rtl/dcache_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
// One-word lines; misses and all writes run a strobe/ack RAM transaction.
module dcache_ctrl #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [65:0] i_cpu_bus,
   input  logic        i_cpu_en,
   output logic [32:0] o_cpu_bus,
   input  logic        i_inv,
   output logic [31:0] o_ram_addr,
   output logic [31:0] o_ram_wdata,
   output logic        o_ram_rd,
   output logic        o_ram_wr,
   input  logic [31:0] i_ram_rdata,
   input  logic        i_ram_ack
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      WR_THRU,
      WR_DONE
   } state_t;

   state_t state, state_nxt;

   logic [LINES-1:0]    valid;
   logic [TAG_BITS-1:0] tag_arr  [LINES];
   logic [31:0]         data_arr [LINES];

   logic [31:0]         lat_addr;
   logic [31:0]         lat_wdata;
   logic                ram_rd_q;
   logic                ram_wr_q;

   logic                req_rd;
   logic                req_wr;
   logic                access;
   logic [31:0]         req_addr;
   logic [31:0]         req_wdata;
   logic [INDEX_BITS-1:0] req_idx;
   logic [INDEX_BITS-1:0] lat_idx;
   logic [TAG_BITS-1:0] req_tag;
   logic [TAG_BITS-1:0] lat_tag;
   logic                req_hit;
   logic                lat_hit;
   logic                latch_en;
   logic                fill;
   logic                wr_upd;
   logic                hit;
   logic [31:0]         rdata;

   assign req_rd    = i_cpu_bus[65];
   assign req_wr    = i_cpu_bus[64];
   assign req_addr  = i_cpu_bus[63:32];
   assign req_wdata = i_cpu_bus[31:0];
   assign access    = i_cpu_en & (req_rd | req_wr);

   assign req_idx = req_addr[INDEX_BITS+1:2];
   assign req_tag = req_addr[31:INDEX_BITS+2];
   assign lat_idx = lat_addr[INDEX_BITS+1:2];
   assign lat_tag = lat_addr[31:INDEX_BITS+2];

   assign req_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign lat_hit = valid[lat_idx] && (tag_arr[lat_idx] == lat_tag);

   assign fill   = (state == RD_MISS) && i_ram_ack;
   assign wr_upd = (state == WR_THRU) && i_ram_ack && lat_hit;

   assign o_cpu_bus   = {hit, rdata};
   assign o_ram_addr  = lat_addr;
   assign o_ram_wdata = lat_wdata;
   assign o_ram_rd    = ram_rd_q;
   assign o_ram_wr    = ram_wr_q;

   // State register, request latches and registered RAM strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         ram_rd_q  <= 1'b0;
         ram_wr_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         ram_rd_q <= (state_nxt == RD_MISS);
         ram_wr_q <= (state_nxt == WR_THRU);
         if (latch_en) begin
            lat_addr  <= req_addr & ~32'h3;
            lat_wdata <= req_wdata;
         end
      end
   end

   // Valid bits: invalidate beats a same-cycle fill
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else if (i_inv) begin
         valid <= '0;
      end else if (fill) begin
         valid[lat_idx] <= 1'b1;
      end
   end

   // Tag/data arrays: fill on read ack, update only on a write hit
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_arr[lat_idx]  <= lat_tag;
         data_arr[lat_idx] <= i_ram_rdata;
      end else if (wr_upd) begin
         data_arr[lat_idx] <= lat_wdata;
      end
   end

   // Next state and combinational response to the MA stage
   always_comb begin
      state_nxt = state;
      hit       = 1'b0;
      rdata     = '0;
      latch_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!access) begin
               hit = 1'b1;
            end else if (req_wr) begin
               latch_en  = 1'b1;
               state_nxt = WR_THRU;
            end else if (req_hit) begin
               hit   = 1'b1;
               rdata = data_arr[req_idx];
            end else begin
               latch_en  = 1'b1;
               state_nxt = RD_MISS;
            end
         end
         RD_MISS: begin
            if (i_ram_ack) state_nxt = IDLE;
         end
         WR_THRU: begin
            if (i_ram_ack) state_nxt = WR_DONE;
         end
         WR_DONE: begin
            hit       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
